// File: rtl/rca_pipe.sv
// rca_pipe: pipelined ripple-carry adder/subtractor; WIDTH bits rippled in STAGES registered segments.
// Optional signed-overflow port `ovf` is built only when RCA_PIPE_OVF_EN is defined.

module rca_pipe_chk #(
  parameter int WIDTH = 32
) (
  input logic             clk,
  input logic             reset,
  input logic             in_ready,
  input logic             out_valid,
  input logic             out_ready,
  input logic [WIDTH-1:0] sum,
  input logic             cout
);
  // A result refused by the consumer must stay put until it is taken.
  a_hold: assert property (@(posedge clk) disable iff (!reset)
    (out_valid && !out_ready) |=> (out_valid && $stable(sum) && $stable(cout)));

  a_ready: assert property (@(posedge clk) disable iff (!reset)
    in_ready == !(out_valid && !out_ready));
endmodule

module rca_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef RCA_PIPE_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int SEG = WIDTH / STAGES;

  // Stage 0 is the input register; stage k+1 holds the result of rippling segment k.
  logic [STAGES:0]              v_r;
  logic [STAGES:0]              c_r;
  logic [STAGES:0][WIDTH-1:0]   s_r;
  logic [STAGES-1:0][WIDTH-1:0] x_r;
  logic [STAGES-1:0][WIDTH-1:0] y_r;
  logic [STAGES-1:0][WIDTH-1:0] s_nxt_s;
  logic [STAGES-1:0]            c_nxt_s;
  logic                         stall_s;
`ifdef RCA_PIPE_OVF_EN
  logic                         c_msb_s;
  logic                         ovf_r;
`endif

  function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
    return {(x & y) | ((x ^ y) & c), x ^ y ^ c};
  endfunction

  assign stall_s   = v_r[STAGES] && !out_ready;
  assign in_ready  = !stall_s;
  assign out_valid = v_r[STAGES];
  assign sum       = s_r[STAGES];
  assign cout      = c_r[STAGES];
`ifdef RCA_PIPE_OVF_EN
  assign ovf       = ovf_r;
`endif

  // Ripple each segment from the carry registered by the stage before it.
  always_comb begin
    logic [1:0] fa_v;
    logic       c_v;
    fa_v    = 2'b00;
    c_v     = 1'b0;
    s_nxt_s = '0;
    c_nxt_s = '0;
`ifdef RCA_PIPE_OVF_EN
    c_msb_s = 1'b0;
`endif
    for (int k = 0; k < STAGES; k++) begin
      s_nxt_s[k] = s_r[k];
      c_v        = c_r[k];
      for (int i = 0; i < SEG; i++) begin
`ifdef RCA_PIPE_OVF_EN
        c_msb_s = ((k == STAGES - 1) && (i == SEG - 1)) ? c_v : c_msb_s;
`endif
        fa_v                  = full_add(x_r[k][k*SEG+i], y_r[k][k*SEG+i], c_v);
        s_nxt_s[k][k*SEG+i]   = fa_v[0];
        c_v                   = fa_v[1];
      end
      c_nxt_s[k] = c_v;
    end
  end

  // Whole pipe advances together unless the output is stalled; the last stage only loads valid beats.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v_r <= '0;
      c_r <= '0;
      s_r <= '0;
      x_r <= '0;
      y_r <= '0;
`ifdef RCA_PIPE_OVF_EN
      ovf_r <= 1'b0;
`endif
    end else if (!stall_s) begin
      v_r[0] <= in_valid;
      if (in_valid) begin
        x_r[0] <= a;
        y_r[0] <= b ^ {WIDTH{sub}};
        c_r[0] <= sub | cin;
      end
      for (int k = 1; k < STAGES; k++) begin
        v_r[k] <= v_r[k-1];
        x_r[k] <= x_r[k-1];
        y_r[k] <= y_r[k-1];
        s_r[k] <= s_nxt_s[k-1];
        c_r[k] <= c_nxt_s[k-1];
      end
      v_r[STAGES] <= v_r[STAGES-1];
      if (v_r[STAGES-1]) begin
        s_r[STAGES] <= s_nxt_s[STAGES-1];
        c_r[STAGES] <= c_nxt_s[STAGES-1];
`ifdef RCA_PIPE_OVF_EN
        ovf_r       <= c_msb_s ^ c_nxt_s[STAGES-1];
`endif
      end
    end
  end

  rca_pipe_chk #(.WIDTH(WIDTH)) u_chk (
    .clk       (clk),
    .reset     (reset),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );
endmodule

// File: tb/tb_rca_pipe.sv
// Directed bench for rca_pipe: 8-bit/2-stage instance plus 32-bit instances with 32 and 1 stages.
module tb_rca_pipe;
  logic clk;
  logic reset;

  logic       in_valid8, in_ready8, cin8, sub8, out_valid8, out_ready8, cout8, ovf8;
  logic [7:0] a8, b8, sum8;

  logic        in_valid32, cin32, sub32, out_ready32;
  logic [31:0] a32, b32;
  logic        in_ready32a, out_valid32a, cout32a, ovf32a;
  logic        in_ready32b, out_valid32b, cout32b, ovf32b;
  logic [31:0] sum32a, sum32b;

  int n_checks = 0;
  int n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  rca_pipe #(.WIDTH(8), .STAGES(2)) u_dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8), .sub(sub8),
    .out_valid(out_valid8), .out_ready(out_ready8), .sum(sum8), .cout(cout8)
`ifdef RCA_PIPE_OVF_EN
    , .ovf(ovf8)
`endif
  );

  rca_pipe #(.WIDTH(32), .STAGES(32)) u_dut32a (
    .clk(clk), .reset(reset), .in_valid(in_valid32), .in_ready(in_ready32a),
    .a(a32), .b(b32), .cin(cin32), .sub(sub32),
    .out_valid(out_valid32a), .out_ready(out_ready32), .sum(sum32a), .cout(cout32a)
`ifdef RCA_PIPE_OVF_EN
    , .ovf(ovf32a)
`endif
  );

  rca_pipe #(.WIDTH(32), .STAGES(1)) u_dut32b (
    .clk(clk), .reset(reset), .in_valid(in_valid32), .in_ready(in_ready32b),
    .a(a32), .b(b32), .cin(cin32), .sub(sub32),
    .out_valid(out_valid32b), .out_ready(out_ready32), .sum(sum32b), .cout(cout32b)
`ifdef RCA_PIPE_OVF_EN
    , .ovf(ovf32b)
`endif
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] model8(input logic [7:0] ta, input logic [7:0] tb,
                                        input logic tc, input logic ts);
    logic [7:0] bx;
    bx = ts ? ~tb : tb;
    return {1'b0, ta} + {1'b0, bx} + {8'b0, (ts | tc)};
  endfunction

  // returns {ovf, cout, sum}
  function automatic logic [33:0] model32(input logic [31:0] ta, input logic [31:0] tb,
                                          input logic tc, input logic ts);
    logic [31:0] bx;
    logic [32:0] r;
    bx = ts ? ~tb : tb;
    r  = {1'b0, ta} + {1'b0, bx} + {32'b0, (ts | tc)};
    return {(ta[31] == bx[31]) && (r[31] != ta[31]), r};
  endfunction

  task automatic run_vec8(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                          input logic tc, input logic ts,
                          input logic [7:0] es, input logic ec, input logic eo);
    int lat;
    @(negedge clk);
    a8 = ta; b8 = tb; cin8 = tc; sub8 = ts; in_valid8 = 1'b1;
    @(negedge clk);
    in_valid8 = 1'b0;
    lat = 1;
    while (!out_valid8 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check_eq({tag, ".lat"},  64'(lat),  64'(3));
    check_eq({tag, ".sum"},  64'(sum8), 64'(es));
    check_eq({tag, ".cout"}, 64'(cout8), 64'(ec));
`ifdef RCA_PIPE_OVF_EN
    check_eq({tag, ".ovf"},  64'(ovf8), 64'(eo));
`endif
    @(negedge clk);
    check_eq({tag, ".drop"}, 64'(out_valid8), 64'(1'b0));
    check_eq({tag, ".keep"}, 64'(sum8), 64'(es));
  endtask

  task automatic run_vec32(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                           input logic tc, input logic ts,
                           input logic [31:0] es, input logic ec, input logic eo);
    int n, lat_a, lat_b;
    logic [33:0] ra, rb;
    @(negedge clk);
    a32 = ta; b32 = tb; cin32 = tc; sub32 = ts; in_valid32 = 1'b1;
    @(negedge clk);
    in_valid32 = 1'b0;
    n = 1; lat_a = 0; lat_b = 0; ra = '0; rb = '0;
    while ((lat_a == 0 || lat_b == 0) && n < 60) begin
      if (out_valid32a && lat_a == 0) begin lat_a = n; ra = {ovf32a, cout32a, sum32a}; end
      if (out_valid32b && lat_b == 0) begin lat_b = n; rb = {ovf32b, cout32b, sum32b}; end
      @(negedge clk);
      n++;
    end
    check_eq({tag, ".lat32"}, 64'(lat_a), 64'(33));
    check_eq({tag, ".lat1"},  64'(lat_b), 64'(2));
    check_eq({tag, ".res32"}, 64'(ra[32:0]), 64'({ec, es}));
    check_eq({tag, ".res1"},  64'(rb[32:0]), 64'({ec, es}));
`ifdef RCA_PIPE_OVF_EN
    check_eq({tag, ".ovf32"}, 64'(ra[33]), 64'(eo));
    check_eq({tag, ".ovf1"},  64'(rb[33]), 64'(eo));
`endif
  endtask

  initial begin
    logic [7:0]  va [16];
    logic [7:0]  vb [16];
    logic        vc [16];
    logic        vs [16];
    logic [8:0]  q8 [$];
    logic [33:0] qa [$];
    logic [33:0] qb [$];
    logic [8:0]  e8;
    logic [33:0] e32;
    logic [7:0]  held_sum;
    logic        held_cout;
    logic        acc;
    int          idx, got;

    in_valid8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0; sub8 = 1'b0; out_ready8 = 1'b1;
    in_valid32 = 1'b0; a32 = 32'h0; b32 = 32'h0; cin32 = 1'b0; sub32 = 1'b0; out_ready32 = 1'b1;
    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst.valid32a", 64'(out_valid32a), 64'(1'b0));
    check_eq("rst.valid32b", 64'(out_valid32b), 64'(1'b0));
    reset = 1'b1;

    // idle after reset release
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check_eq("idle.valid", 64'(out_valid8), 64'(1'b0));
      check_eq("idle.sum",   64'(sum8),       64'(8'h00));
      check_eq("idle.cout",  64'(cout8),      64'(1'b0));
      check_eq("idle.ready", 64'(in_ready8),  64'(1'b1));
`ifdef RCA_PIPE_OVF_EN
      check_eq("idle.ovf",   64'(ovf8),       64'(1'b0));
`endif
    end

    run_vec8("ff_p_01",  8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    run_vec8("10_m_20",  8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0);
    run_vec8("7f_m_ff",  8'h7F, 8'hFF, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1);
    run_vec8("7f_p_01",  8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    run_vec8("80_p_80",  8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    run_vec8("55_p_aa1", 8'h55, 8'hAA, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    run_vec8("00_m_00c", 8'h00, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0);
    run_vec8("3c_p_0f1", 8'h3C, 8'h0F, 1'b1, 1'b0, 8'h4C, 1'b0, 1'b0);

    // back-to-back stream with the consumer stalling for cycles 5..9
    for (int i = 0; i < 16; i++) begin
      va[i] = 8'($urandom); vb[i] = 8'($urandom);
      vc[i] = 1'($urandom); vs[i] = 1'($urandom);
    end
    idx = 0; got = 0; acc = 1'b0; held_sum = 8'h00; held_cout = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (acc) idx++;
      if (idx < 16) begin
        a8 = va[idx]; b8 = vb[idx]; cin8 = vc[idx]; sub8 = vs[idx]; in_valid8 = 1'b1;
      end else begin
        in_valid8 = 1'b0;
      end
      out_ready8 = (t >= 5 && t <= 9) ? 1'b0 : 1'b1;
      #1;
      acc = in_valid8 && in_ready8;
      if (acc) q8.push_back(model8(a8, b8, cin8, sub8));
      check_eq("stall.in_ready", 64'(in_ready8), 64'((t >= 5 && t <= 9) ? 1'b0 : 1'b1));
      if (t == 5) begin
        check_eq("stall.valid", 64'(out_valid8), 64'(1'b1));
        held_sum = sum8; held_cout = cout8;
      end
      if (t >= 6 && t <= 9) begin
        check_eq("stall.hold_sum",  64'(sum8),  64'(held_sum));
        check_eq("stall.hold_cout", 64'(cout8), 64'(held_cout));
      end
      if (out_valid8 && out_ready8) begin
        got++;
        if (q8.size() == 0) begin
          check_eq("stream.extra", 64'(1'b1), 64'(1'b0));
        end else begin
          e8 = q8.pop_front();
          check_eq("stream.res", 64'({cout8, sum8}), 64'(e8));
        end
      end
    end
    check_eq("stream.count", 64'(got), 64'(16));
    check_eq("stream.left",  64'(q8.size()), 64'(0));
    out_ready8 = 1'b1;

    // reset with three beats in flight
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      a8 = 8'(8'h11 * (i + 1)); b8 = 8'h01; cin8 = 1'b0; sub8 = 1'b0; in_valid8 = 1'b1;
      @(negedge clk);
    end
    in_valid8 = 1'b0;
    check_eq("mid.pre_valid", 64'(out_valid8), 64'(1'b1));
    #2 reset = 1'b0;
    #1;
    check_eq("mid.valid", 64'(out_valid8), 64'(1'b0));
    check_eq("mid.sum",   64'(sum8),       64'(8'h00));
    check_eq("mid.cout",  64'(cout8),      64'(1'b0));
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check_eq("mid.no_stale", 64'(out_valid8), 64'(1'b0));
    end

    // 32-bit instances: directed latency/result vectors
    run_vec32("w_ff_p_1", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    run_vec32("w_0_m_1",  32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_vec32("w_7f_p_1", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    run_vec32("w_mix_c1", 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0, 32'hACF1_3569, 1'b0, 1'b0);
    run_vec32("w_80_m_1", 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    check_eq("w.in_ready32", 64'(in_ready32a), 64'(1'b1));
    check_eq("w.in_ready1",  64'(in_ready32b), 64'(1'b1));

    // 32-bit instances: continuous random add/sub stream
    for (int t = 0; t < 245; t++) begin
      @(negedge clk);
      if (out_valid32a) begin
        if (qa.size() == 0) begin
          check_eq("w32.extra", 64'(1'b1), 64'(1'b0));
        end else begin
          e32 = qa.pop_front();
          check_eq("w32.res", 64'({cout32a, sum32a}), 64'(e32[32:0]));
`ifdef RCA_PIPE_OVF_EN
          check_eq("w32.ovf", 64'(ovf32a), 64'(e32[33]));
`endif
        end
      end
      if (out_valid32b) begin
        if (qb.size() == 0) begin
          check_eq("w1.extra", 64'(1'b1), 64'(1'b0));
        end else begin
          e32 = qb.pop_front();
          check_eq("w1.res", 64'({cout32b, sum32b}), 64'(e32[32:0]));
`ifdef RCA_PIPE_OVF_EN
          check_eq("w1.ovf", 64'(ovf32b), 64'(e32[33]));
`endif
        end
      end
      if (t < 200) begin
        a32 = $urandom; b32 = $urandom; cin32 = 1'($urandom); sub32 = 1'($urandom);
        in_valid32 = 1'b1;
        e32 = model32(a32, b32, cin32, sub32);
        qa.push_back(e32);
        qb.push_back(e32);
      end else begin
        in_valid32 = 1'b0;
      end
    end
    check_eq("w32.left", 64'(qa.size()), 64'(0));
    check_eq("w1.left",  64'(qb.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
